// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encodings, default parameter values and width helper for cpu_run_ctrl.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } run_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_RST_HOLD        = 16;
    localparam int unsigned DEF_CNT_W           = 32;
    localparam int unsigned DEF_WDT_CYCLES      = 100000000;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse when a stable press is accepted.
module btn_debounce
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            // Any sample matching the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run-control sequencer: reset hold, run/halt/single-step gating and cycle count.
// Optional watchdog on continuous RUN time: define CPU_RUN_CTRL_WATCHDOG_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RST_HOLD        = DEF_RST_HOLD,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned WDT_CYCLES      = DEF_WDT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             continue_btn,
    input  logic             step_mode,
    input  logic             cpu_halt,
    output logic             cpu_rst,
    output logic             cpu_ce,
    output logic             resume,
    output logic             pwr,
    output logic             halted,
    output logic [CNT_W-1:0] ce_cnt,
    output logic             wdt_trip
);

    localparam int unsigned HW = cnt_w(RST_HOLD);

    run_state_t    state_q;
    run_state_t    state_d;
    logic [HW-1:0] hold_cnt;
    logic          resume_q;
    logic          set_resume;
    logic          halt_eff;
    logic          cont_pulse;
    logic          wdt_hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (continue_btn),
        .pulse (cont_pulse)
    );

    // The CPU clears its halt latch on the resume edge, so a stale halt is masked then.
    assign halt_eff = cpu_halt & ~resume_q;

    always_comb begin
        state_d    = state_q;
        cpu_ce     = 1'b0;
        set_resume = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                if (hold_cnt == HW'(RST_HOLD - 1))
                    state_d = step_mode ? ST_HALTED : ST_RUN;
            end
            ST_RUN: begin
                cpu_ce = ~halt_eff;
                if (halt_eff || step_mode || wdt_hit)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (cont_pulse) begin
                    state_d    = step_mode ? ST_STEP : ST_RUN;
                    set_resume = 1'b1;
                end
            end
            ST_STEP: begin
                cpu_ce  = 1'b1;
                state_d = ST_HALTED;
            end
            default: state_d = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RST_HOLD;
            hold_cnt <= '0;
            resume_q <= 1'b0;
            ce_cnt   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= set_resume;
            ce_cnt   <= ce_cnt + CNT_W'(cpu_ce);
            if (state_q == ST_RST_HOLD && state_d == ST_RST_HOLD)
                hold_cnt <= hold_cnt + HW'(1);
            else
                hold_cnt <= '0;
        end
    end

    assign cpu_rst = (state_q == ST_RST_HOLD);
    assign pwr     = ~cpu_rst;
    assign halted  = (state_q == ST_HALTED);
    assign resume  = resume_q;

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    localparam int unsigned WW = cnt_w(WDT_CYCLES);

    logic [WW-1:0] wdt_cnt;
    logic          wdt_q;
    logic          trip;

    assign wdt_hit = (wdt_cnt == WW'(WDT_CYCLES - 1));
    // Only a trip that actually causes the halt sets the flag.
    assign trip    = (state_q == ST_RUN) && !halt_eff && !step_mode && wdt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else begin
            if (state_q != ST_RUN || state_d != ST_RUN)
                wdt_cnt <= '0;
            else if (cpu_ce)
                wdt_cnt <= wdt_cnt + WW'(1);
            if (trip)
                wdt_q <= 1'b1;
            else if (set_resume)
                wdt_q <= 1'b0;
        end
    end

    assign wdt_trip = wdt_q;
`else
    // WDT_CYCLES stays in the interface so both builds share one parameter list.
    assign wdt_hit  = 1'b0 & (WDT_CYCLES == 0);
    assign wdt_trip = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl; the watchdog section follows CPU_RUN_CTRL_WATCHDOG_EN.
module tb_cpu_run_ctrl;

    localparam int LAT = 6;   // DEBOUNCE_CYCLES + 2 with DEBOUNCE_CYCLES = 4

    logic       clk;
    logic       reset;
    logic       continue_btn;
    logic       step_mode;
    logic       cpu_halt;
    logic       cpu_rst;
    logic       cpu_ce;
    logic       resume;
    logic       pwr;
    logic       halted;
    logic [7:0] ce_cnt;
    logic       wdt_trip;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD       (3),
        .CNT_W          (8),
        .WDT_CYCLES     (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .continue_btn (continue_btn),
        .step_mode    (step_mode),
        .cpu_halt     (cpu_halt),
        .cpu_rst      (cpu_rst),
        .cpu_ce       (cpu_ce),
        .resume       (resume),
        .pwr          (pwr),
        .halted       (halted),
        .ce_cnt       (ce_cnt),
        .wdt_trip     (wdt_trip)
    );

    typedef enum int {S_RST, S_CE, S_RES, S_PWR, S_HLT, S_CNT, S_WDT} sig_t;
    typedef struct {
        int   when;
        sig_t sig;
        int   val;
    } snap_t;

    snap_t snap_q[$];
    int    res_q[$];      // expected ce_cnt at each resume pulse
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input sig_t s);
        case (s)
            S_RST:   return {31'd0, cpu_rst};
            S_CE:    return {31'd0, cpu_ce};
            S_RES:   return {31'd0, resume};
            S_PWR:   return {31'd0, pwr};
            S_HLT:   return {31'd0, halted};
            S_CNT:   return {24'd0, ce_cnt};
            default: return {31'd0, wdt_trip};
        endcase
    endfunction

    task automatic exp_at(input int dly, input sig_t s, input int v);
        snap_q.push_back('{when: cyc + dly, sig: s, val: v});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares due snapshots and every resume pulse against the scoreboard.
    always @(negedge clk) begin
        int i;
        int e;
        i = 0;
        while (i < snap_q.size()) begin
            if (snap_q[i].when <= cyc) begin
                checks++;
                if (snap_q[i].when < cyc || get_sig(snap_q[i].sig) !== 32'(snap_q[i].val)) begin
                    failures++;
                    $display("FAIL %s @cyc %0d (due %0d): got %0d expected %0d", snap_q[i].sig.name(),
                             cyc, snap_q[i].when, get_sig(snap_q[i].sig), snap_q[i].val);
                end
                snap_q.delete(i);
            end else begin
                i++;
            end
        end
        if (resume === 1'b1) begin
            checks++;
            if (res_q.size() == 0) begin
                failures++;
                $display("FAIL resume_unexpected @cyc %0d: got pulse expected none", cyc);
            end else begin
                e = res_q.pop_front();
                if (ce_cnt !== 8'(e) || cpu_ce !== 1'b1 || halted !== 1'b0 || wdt_trip !== 1'b0) begin
                    failures++;
                    $display("FAIL resume_state @cyc %0d: got cnt=%0d ce=%b halted=%b wdt=%b expected cnt=%0d ce=1 halted=0 wdt=0",
                             cyc, ce_cnt, cpu_ce, halted, wdt_trip, e);
                end
            end
        end
    end

    // One clean press; base is ce_cnt expected during the resume cycle.
    task automatic press(input bit to_step, input int base);
        int n;
        bit seen;
        res_q.push_back(base);
        continue_btn = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = (resume === 1'b1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL press_timeout @cyc %0d: got no resume expected latency %0d", cyc, LAT);
        end else begin
            if (n - 1 != LAT) begin
                failures++;
                $display("FAIL press_latency @cyc %0d: got %0d expected %0d", cyc, n - 1, LAT);
            end
            cpu_halt = 1'b0;
            exp_at(1, S_CNT, base + 1);
            exp_at(1, S_HLT, to_step ? 1 : 0);
            exp_at(1, S_CE, to_step ? 0 : 1);
            exp_at(1, S_RES, 0);
        end
        while (n < 10) begin
            tick();
            n++;
        end
        continue_btn = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout @cyc %0d: got no finish expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        continue_btn = 1'b0;
        step_mode    = 1'b0;
        cpu_halt     = 1'b0;

        // Power-up
        repeat (2) tick();
        exp_at(0, S_RST, 1); exp_at(0, S_CE, 0);  exp_at(0, S_RES, 0); exp_at(0, S_PWR, 0);
        exp_at(0, S_HLT, 0); exp_at(0, S_CNT, 0); exp_at(0, S_WDT, 0);
        reset = 1'b0;
        exp_at(1, S_RST, 1); exp_at(2, S_RST, 1);
        exp_at(3, S_RST, 0); exp_at(3, S_PWR, 1); exp_at(3, S_CE, 1); exp_at(3, S_CNT, 0);
        exp_at(8, S_CNT, 5);
        repeat (8) tick();

        // Halt, bouncing button, continue
        cpu_halt = 1'b1;
        exp_at(0, S_CE, 0); exp_at(0, S_HLT, 0);
        exp_at(1, S_HLT, 1); exp_at(1, S_CE, 0); exp_at(1, S_CNT, 5);
        tick();
        continue_btn = 1'b1; tick();
        continue_btn = 1'b0; tick();
        press(1'b0, 5);

        // Single-step from a fresh reset
        step_mode = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        exp_at(3, S_HLT, 1); exp_at(3, S_CE, 0); exp_at(3, S_CNT, 0); exp_at(3, S_PWR, 1);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) press(1'b1, k);
        exp_at(0, S_CNT, 3); exp_at(0, S_HLT, 1);
        tick();

        // Counter wrap, then mid-run reset
        step_mode = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
`ifndef CPU_RUN_CTRL_WATCHDOG_EN
        exp_at(257, S_CNT, 254); exp_at(258, S_CNT, 255); exp_at(259, S_CNT, 0);
        exp_at(259, S_CE, 1);
        repeat (259) tick();
`else
        exp_at(8, S_CNT, 5);
        repeat (8) tick();
`endif
        reset = 1'b1;
        exp_at(0, S_RST, 0);
        exp_at(1, S_RST, 1); exp_at(1, S_CNT, 0); exp_at(1, S_PWR, 0); exp_at(1, S_CE, 0);
        tick();
        reset = 1'b0;

        // Long free run: watchdog trips only when enabled
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
        exp_at(22, S_HLT, 0); exp_at(22, S_WDT, 0); exp_at(22, S_CE, 1);
        exp_at(23, S_HLT, 1); exp_at(23, S_WDT, 1); exp_at(23, S_CE, 0); exp_at(23, S_CNT, 20);
        repeat (23) tick();
        press(1'b0, 20);
        exp_at(0, S_WDT, 0); exp_at(0, S_HLT, 0);
        tick();
`else
        exp_at(23, S_HLT, 0); exp_at(23, S_CE, 1); exp_at(23, S_WDT, 0); exp_at(23, S_CNT, 20);
        exp_at(40, S_HLT, 0); exp_at(40, S_WDT, 0); exp_at(40, S_CNT, 37);
        repeat (41) tick();
`endif

        repeat (2) tick();
        checks++;
        if (res_q.size() != 0 || snap_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d resume and %0d snapshot entries left expected 0",
                     res_q.size(), snap_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
